// File: rtl/sleep_tick_sched.sv
// sleep_tick_sched: four-channel tick-driven countdown scheduler with an Avalon-MM slave register file
// Optional feature macro: SLEEP_TICK_SCHED_WAKE_EN adds the wake output.
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   reset_n    - asynchronous active-low reset
//   tick       - interval timer pulse, one countdown step per high cycle
//   address    - register word address (0 STATUS, 1 CONTROL, 2 CHSEL, 3 COUNT, 4..7 PERIOD0..3)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - registered read data, one cycle after the address
//   irq        - OR over channels of pending & irq_en
//   wake       - OR of all pending bits (only with SLEEP_TICK_SCHED_WAKE_EN)
module sleep_tick_sched #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
`ifdef SLEEP_TICK_SCHED_WAKE_EN
    ,
    output logic        wake
`endif
);
    logic [CNT_W-1:0] period   [4];
    logic [CNT_W-1:0] count    [4];
    logic [CNT_W-1:0] period_d [4];
    logic [CNT_W-1:0] count_d  [4];
    logic [3:0]       pending, enable, periodic, irq_en;
    logic [3:0]       pending_d, enable_d;
    logic [1:0]       sel;
    logic [15:0]      rd_d;
    logic             wr, wr_status, wr_ctrl;

    assign wr        = chipselect && !write_n;
    assign wr_status = wr && address == 3'd0;
    assign wr_ctrl   = wr && address == 3'd1;

    always_comb begin
        pending_d = pending & ~(wr_status ? writedata[3:0] : 4'h0);
        enable_d  = wr_ctrl ? writedata[3:0] : enable;
        period_d  = period;
        count_d   = count;
        for (int i = 0; i < 4; i++) begin
            if (wr && address == 3'(4 + i))
                period_d[i] = writedata[CNT_W-1:0];
            // a load preempts a same-cycle tick for this channel only
            if ((wr && address == 3'(4 + i)) || (wr_ctrl && writedata[i] && !enable[i]))
                count_d[i] = period_d[i];
            else if (tick && enable[i] && period[i] != '0 && count[i] != '0) begin
                if (count[i] == CNT_W'(1)) begin
                    // expiry overrides a same-cycle write-1-to-clear
                    pending_d[i] = 1'b1;
                    count_d[i]   = periodic[i] ? period[i] : '0;
                    if (!periodic[i])
                        enable_d[i] = 1'b0;
                end else
                    count_d[i] = count[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_d = '0;
        case (address)
            3'd0:    rd_d = {12'h0, pending};
            3'd1:    rd_d = {4'h0, irq_en, periodic, enable};
            3'd2:    rd_d = {14'h0, sel};
            3'd3:    rd_d = 16'(count[sel]);
            default: rd_d = 16'(period[address[1:0]]);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period   <= '{default: '0};
            count    <= '{default: '0};
            pending  <= '0;
            enable   <= '0;
            periodic <= '0;
            irq_en   <= '0;
            sel      <= '0;
            readdata <= '0;
        end else begin
            period   <= period_d;
            count    <= count_d;
            pending  <= pending_d;
            enable   <= enable_d;
            readdata <= rd_d;
            if (wr_ctrl) begin
                periodic <= writedata[7:4];
                irq_en   <= writedata[11:8];
            end
            if (wr && address == 3'd2)
                sel <= writedata[1:0];
        end
    end

    assign irq = |(pending & irq_en);

`ifdef SLEEP_TICK_SCHED_WAKE_EN
    assign wake = |pending;
`endif
endmodule

// File: tb/tb_sleep_tick_sched.sv
// tb_sleep_tick_sched: scoreboard-driven bench for sleep_tick_sched
module tb_sleep_tick_sched;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        tick = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
`ifdef SLEEP_TICK_SCHED_WAKE_EN
    logic        wake;
`endif

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [15:0] exp_q [$];
    string       name_q [$];
    logic        rd_valid;
    logic [15:0] exp_v;
    string       exp_n;

    always #5 clk = ~clk;

    sleep_tick_sched dut (
        .clk(clk),
        .reset_n(reset_n),
        .tick(tick),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
`ifdef SLEEP_TICK_SCHED_WAKE_EN
        ,
        .wake(wake)
`endif
    );

    always @(posedge clk or negedge reset_n)
        if (!reset_n) rd_valid <= 1'b0;
        else          rd_valid <= chipselect && write_n;

    always @(negedge clk)
        if (rd_valid) begin
            total_cnt++;
            if (exp_q.size() == 0)
                $display("FAIL unexpected_read: readdata=%h with empty scoreboard", readdata);
            else begin
                exp_v = exp_q.pop_front();
                exp_n = name_q.pop_front();
                if (readdata !== exp_v)
                    $display("FAIL %s: readdata=%h expected=%h", exp_n, readdata, exp_v);
                else
                    pass_cnt++;
            end
        end

    task automatic drive(input logic t, input logic cs, input logic wn, input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        tick = t; chipselect = cs; write_n = wn; address = a; writedata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        drive(1'b0, 1'b1, 1'b0, a, d);
        idle();
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        drive(1'b0, 1'b1, 1'b1, a, 16'h0);
        idle();
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b1, 3'd0, 16'h0);
        idle();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq: irq=%b expected=0", irq);
        else pass_cnt++;
        total_cnt++;
        if (readdata !== 16'h0) $display("FAIL reset_readdata: readdata=%h expected=0000", readdata);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0, $sformatf("reset_reg%0d", a));
    endtask

    task automatic test_oneshot();
        wr(3'd4, 16'd3);
        wr(3'd1, 16'h0101);
        ticks(2);
        rd(3'd3, 16'd1, "oneshot_count_after2");
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_early: irq=%b expected=0", irq);
        else pass_cnt++;
        ticks(1);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq: irq=%b expected=1", irq);
        else pass_cnt++;
        rd(3'd0, 16'h0001, "oneshot_status");
        rd(3'd1, 16'h0100, "oneshot_control");
        rd(3'd3, 16'd0, "oneshot_count_end");
        wr(3'd0, 16'h0001);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_cleared: irq=%b expected=0", irq);
        else pass_cnt++;
        rd(3'd0, 16'h0000, "oneshot_status_cleared");
    endtask

    task automatic test_periodic();
        logic exp_irq;
        wr(3'd5, 16'd2);
        wr(3'd1, 16'h0222);
        wr(3'd2, 16'd1);
        for (int k = 1; k <= 6; k++) begin
            ticks(1);
            exp_irq = (k % 2 == 0);
            total_cnt++;
            if (irq !== exp_irq) $display("FAIL periodic_irq_t%0d: irq=%b expected=%b", k, irq, exp_irq);
            else pass_cnt++;
            if (exp_irq) begin
                rd(3'd0, 16'h0002, $sformatf("periodic_status_t%0d", k));
                rd(3'd3, 16'd2, $sformatf("periodic_reload_t%0d", k));
                wr(3'd0, 16'h0002);
                rd(3'd0, 16'h0000, $sformatf("periodic_cleared_t%0d", k));
            end else
                rd(3'd3, 16'd1, $sformatf("periodic_count_t%0d", k));
        end
        wr(3'd1, 16'h0000);
        ticks(2);
        rd(3'd3, 16'd2, "periodic_frozen");
    endtask

    task automatic test_set_wins();
        wr(3'd4, 16'd1);
        wr(3'd1, 16'h0001);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0001);
        idle();
        rd(3'd0, 16'h0001, "setwins_status");
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL setwins_irq_masked: irq=%b expected=0", irq);
        else pass_cnt++;
        rd(3'd1, 16'h0000, "setwins_enable_cleared");
        wr(3'd0, 16'h0001);
        rd(3'd0, 16'h0000, "setwins_status_cleared");
    endtask

    task automatic test_load_priority();
        wr(3'd6, 16'd1);
        wr(3'd1, 16'h0004);
        wr(3'd2, 16'd2);
        drive(1'b1, 1'b1, 1'b0, 3'd6, 16'd5);
        idle();
        rd(3'd0, 16'h0000, "loadpri_no_expiry");
        rd(3'd3, 16'd5, "loadpri_count");
        rd(3'd6, 16'd5, "loadpri_period");
        ticks(1);
        rd(3'd3, 16'd4, "loadpri_count_dec");
    endtask

    task automatic test_zero_period();
        wr(3'd7, 16'd0);
        wr(3'd1, 16'h0008);
        wr(3'd2, 16'd3);
        ticks(10);
        rd(3'd0, 16'h0000, "zeroper_status");
        rd(3'd3, 16'd0, "zeroper_count");
        rd(3'd1, 16'h0008, "zeroper_control");
    endtask

    task automatic test_reset_midrun();
        wr(3'd4, 16'd1);
        wr(3'd5, 16'd4);
        wr(3'd1, 16'h0303);
        ticks(1);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL midrun_irq_before: irq=%b expected=1", irq);
        else pass_cnt++;
        rd(3'd0, 16'h0001, "midrun_status_before");
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL midrun_irq_reset: irq=%b expected=0", irq);
        else pass_cnt++;
        total_cnt++;
        if (readdata !== 16'h0) $display("FAIL midrun_readdata_reset: readdata=%h expected=0000", readdata);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ticks(5);
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0, $sformatf("midrun_reg%0d", a));
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL midrun_irq_after: irq=%b expected=0", irq);
        else pass_cnt++;
    endtask

`ifdef SLEEP_TICK_SCHED_WAKE_EN
    task automatic test_wake();
        wr(3'd4, 16'd1);
        wr(3'd1, 16'h0001);
        ticks(1);
        total_cnt++;
        if (wake !== 1'b1) $display("FAIL wake_set: wake=%b expected=1", wake);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL wake_irq_masked: irq=%b expected=0", irq);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_set_wins();
        test_load_priority();
        test_zero_period();
        test_reset_midrun();
`ifdef SLEEP_TICK_SCHED_WAKE_EN
        test_wake();
`endif
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: %0d reads outstanding expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sleep_tick_sched.md
SLEEP_TICK_SCHED -- requirements
Module: sleep_tick_sched

Interface
REQ-001 Parameter: CNT_W, 16, width of each channel period and count register (2..16).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: tick  input  1  one-cycle pulse from the interval timer timeout; a multi-cycle high counts as one tick per high cycle.
REQ-005 Port: address  input  3  Avalon slave word address.
REQ-006 Port: chipselect  input  1  slave select.
REQ-007 Port: write_n  input  1  active-low write strobe.
REQ-008 Port: writedata  input  16  write data.
REQ-009 Port: readdata  output  16  registered read data, valid one cycle after address presented.
REQ-010 Port: irq  output  1  level interrupt: OR over channels of (pending AND irq_en).

Function
REQ-011 Four independent countdown channels SHALL share the single tick input.
REQ-012 Register map SHALL be: 0 STATUS (pending[3:0], write-1-to-clear); 1 CONTROL (enable[3:0], periodic[7:4], irq_en[11:8]); 2 CHSEL (sel[1:0]); 3 COUNT (read-only, count of channel sel); 4..7 PERIOD of channels 0..3 (writedata[CNT_W-1:0]).
REQ-013 Writes SHALL occur when chipselect=1 and write_n=0; reads of unused bits SHALL return 0; readdata SHALL update every cycle from the read mux (1-cycle latency, no wait states).
REQ-014 A channel's count SHALL load its period on (a) a PERIOD write to that channel or (b) a CONTROL write changing its enable bit 0->1.
REQ-015 On a tick cycle, each enabled channel with count>1 SHALL decrement count by 1.
REQ-016 On a tick cycle, an enabled channel with count==1 SHALL expire: set pending; if periodic, reload period; else load 0 and clear its enable bit.
REQ-017 A channel with count==0 or period==0 SHALL never expire and SHALL hold count unchanged.
REQ-018 Load (REQ-014) in the same cycle as tick SHALL take priority; that tick is ignored for that channel only.
REQ-019 Expiry in the same cycle as a STATUS write-1-clear of the same bit SHALL leave pending set (set wins).
REQ-020 Clearing an enable bit SHALL freeze count at its current value; pending bits are unaffected by enable.
REQ-021 irq SHALL be combinational from registered pending and irq_en, asserting the cycle after expiry.
REQ-022 Arithmetic SHALL be unsigned CNT_W-bit; a PERIOD write SHALL truncate writedata to CNT_W bits.

Reset
REQ-023 On reset_n low, all registers (count, period, pending, enable, periodic, irq_en, sel, readdata) SHALL clear to 0 asynchronously; irq SHALL be 0.
REQ-024 Reset deasserted mid-countdown SHALL leave all channels disabled; no expiry until reprogrammed.

Configuration
REQ-025 Macro SLEEP_TICK_SCHED_WAKE_EN defined SHALL add output port wake (1 bit) = OR of all pending bits, independent of irq_en, for the sleep-exit logic.
REQ-026 Macro undefined SHALL omit the wake port and its logic; all other behaviour identical.

Verification
REQ-027 PERIOD0=3, CONTROL=0x0101, 3 ticks -> pending[0]=1 after 3rd tick, irq=1 next cycle, enable[0] cleared, COUNT(sel=0)=0.
REQ-028 PERIOD1=2, CONTROL=0x0222, 6 ticks -> pending[1] set after ticks 2, 4, 6; write STATUS=0x2 between expiries clears it; count reloads to 2 each expiry.
REQ-029 Channel 0 count==1, tick and STATUS write 0x1 same cycle -> pending[0] remains 1.
REQ-030 Channel 2 count==1, tick and PERIOD2 write 5 same cycle -> no expiry, count=5.
REQ-031 PERIOD3=0, enable[3]=1, 10 ticks -> pending[3]=0, count=0; reset_n pulsed mid-run on active channels -> all readdata 0, irq=0, counts frozen at 0.
REQ-032 With SLEEP_TICK_SCHED_WAKE_EN, irq_en=0 and channel expiry -> wake=1, irq=0.
